// File: rtl/axi4_stream_traffic_pkg.sv
// Shared encodings and helpers for the AXI4-Stream traffic initiator/target family.
// Contents:
//   MODE_*        target sequence mode (single pass or endless loop)
//   TLAST_*       which counter boundary the TLAST flag is expected on
//   duty_state_e  states of the tready duty-cycle generator
//   exp_tlast()   expected TLAST given the trigger and counter-at-zero flags
package axi4_stream_traffic_pkg;

    localparam logic MODE_SINGLE = 1'b0;
    localparam logic MODE_LOOP   = 1'b1;

    localparam logic [2:0] TLAST_NONE     = 3'd0;
    localparam logic [2:0] TLAST_TRANSFER = 3'd1;
    localparam logic [2:0] TLAST_PACKET   = 3'd2;
    localparam logic [2:0] TLAST_FRAME    = 3'd3;
    localparam logic [2:0] TLAST_STREAM   = 3'd4;

    // DUTY_RESET only exists while reset is held so that tready reads 0 then.
    typedef enum logic [1:0] {
        DUTY_RESET  = 2'd0,
        DUTY_ACTIVE = 2'd1,
        DUTY_PAUSE  = 2'd2
    } duty_state_e;

    function automatic logic exp_tlast(input logic [2:0] trigger,
                                       input logic       xfer0,
                                       input logic       pkt0,
                                       input logic       frm0);
        logic result;
        case (trigger)
            TLAST_NONE:     result = 1'b0;
            TLAST_TRANSFER: result = 1'b1;
            TLAST_PACKET:   result = xfer0;
            TLAST_FRAME:    result = xfer0 & pkt0;
            TLAST_STREAM:   result = xfer0 & pkt0 & frm0;
            default:        result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/axi4_stream_target_type_2_chan.sv
// Per-stream sequence tracker for the multi-stream AXI4-Stream target.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   accept     this stream's transfer was accepted this cycle
//   exp_data   TDATA value expected on the next transfer of this stream
//   exp_last   TLAST value expected on the next transfer of this stream
//   done       single-pass mode: the whole stream has been received
module axi4_stream_target_type_2_chan
    import axi4_stream_traffic_pkg::*;
#(
    parameter int                    TDataWidth         = 32,
    parameter logic                  TargetMode         = MODE_LOOP,
    parameter logic [2:0]            TlastTrigger       = TLAST_PACKET,
    parameter int                    TransfersPerPacket = 4,
    parameter int                    PacketsPerFrame    = 2,
    parameter int                    FramesPerStream    = 2,
    parameter logic [TDataWidth-1:0] TDataStart         = {TDataWidth{1'b0}},
    parameter logic [TDataWidth-1:0] TDataIncr          = {TDataWidth{1'b0}}
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  accept,
    output logic [TDataWidth-1:0] exp_data,
    output logic                  exp_last,
    output logic                  done
);

    // A zero count means one, so every counter has at least one state.
    localparam int XferN = (TransfersPerPacket < 1) ? 1 : TransfersPerPacket;
    localparam int PktN  = (PacketsPerFrame    < 1) ? 1 : PacketsPerFrame;
    localparam int FrmN  = (FramesPerStream    < 1) ? 1 : FramesPerStream;
    localparam int XferW = (XferN > 1) ? $clog2(XferN) : 1;
    localparam int PktW  = (PktN  > 1) ? $clog2(PktN)  : 1;
    localparam int FrmW  = (FrmN  > 1) ? $clog2(FrmN)  : 1;
    localparam logic [XferW-1:0] XferMax = XferW'(XferN - 1);
    localparam logic [PktW-1:0]  PktMax  = PktW'(PktN - 1);
    localparam logic [FrmW-1:0]  FrmMax  = FrmW'(FrmN - 1);

    logic [XferW-1:0]      xfer_r;
    logic [PktW-1:0]       pkt_r;
    logic [FrmW-1:0]       frm_r;
    logic [TDataWidth-1:0] exp_r;
    logic                  done_r;
    logic                  xfer_zero_s;
    logic                  pkt_zero_s;
    logic                  frm_zero_s;
    logic                  stream_last_s;

    assign xfer_zero_s   = (xfer_r == {XferW{1'b0}});
    assign pkt_zero_s    = (pkt_r  == {PktW{1'b0}});
    assign frm_zero_s    = (frm_r  == {FrmW{1'b0}});
    assign stream_last_s = xfer_zero_s & pkt_zero_s & frm_zero_s;

    assign exp_data = exp_r;
    assign exp_last = exp_tlast(TlastTrigger, xfer_zero_s, pkt_zero_s, frm_zero_s);
    assign done     = done_r;

    // Nested down-counters and expected data advance on every accepted transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_r <= XferMax;
            pkt_r  <= PktMax;
            frm_r  <= FrmMax;
            exp_r  <= TDataStart;
            done_r <= 1'b0;
        end else if (accept && !done_r) begin
            xfer_r <= xfer_zero_s ? XferMax : xfer_r - XferW'(1'b1);
            if (xfer_zero_s) begin
                pkt_r <= pkt_zero_s ? PktMax : pkt_r - PktW'(1'b1);
            end
            if (xfer_zero_s && pkt_zero_s) begin
                frm_r <= frm_zero_s ? FrmMax : frm_r - FrmW'(1'b1);
            end
            // Counters reload on their own at the stream end; data restarts only when looping.
            if (stream_last_s && (TargetMode == MODE_LOOP)) begin
                exp_r <= TDataStart;
            end else begin
                exp_r <= exp_r + TDataIncr;
            end
            if (stream_last_s && (TargetMode == MODE_SINGLE)) begin
                done_r <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi4_stream_target_type_2.sv
// Multi-stream AXI4-Stream sink/checker keyed by TID.
// Ports:
//   clk_s_axis_i, rst_s_axis_i    clock, synchronous active-high reset
//   s_axis_*                      AXI4-Stream slave (tvalid/tready/tdata/tlast/tid/tdest)
//   s_axis_terror_o               sticky error flag since reset
//   error_count_o                 saturating count of erroneous transfers
//   first_err_tid_o/_data_o       TID and TDATA of the first erroneous transfer
//   stream_done_o, all_done_o     single-pass completion per stream / all streams
module axi4_stream_target_type_2
    import axi4_stream_traffic_pkg::*;
#(
    parameter int                    TDataWidth         = 32,
    parameter int                    TIdWidth           = 4,
    parameter int                    TDestWidth         = 4,
    parameter int                    NumStreams         = 2,
    parameter int                    TIdBase            = 0,
    parameter int                    TDest              = 0,
    parameter logic                  TargetMode         = MODE_LOOP,
    parameter logic [2:0]            TlastTrigger       = TLAST_PACKET,
    parameter int                    TransfersPerPacket = 4,
    parameter int                    PacketsPerFrame    = 2,
    parameter int                    FramesPerStream    = 2,
    parameter int                    CyclesActive       = 0,
    parameter int                    CyclesPause        = 0,
    parameter logic [TDataWidth-1:0] TDataInit          = TDataWidth'(32'hA0),
    parameter logic [TDataWidth-1:0] TDataIncr          = TDataWidth'(32'h01)
) (
    input  logic                  clk_s_axis_i,
    input  logic                  rst_s_axis_i,
    input  logic                  s_axis_tvalid_i,
    output logic                  s_axis_tready_o,
    input  logic [TDataWidth-1:0] s_axis_tdata_i,
    input  logic                  s_axis_tlast_i,
    input  logic [TIdWidth-1:0]   s_axis_tid_i,
    input  logic [TDestWidth-1:0] s_axis_tdest_i,
    output logic                  s_axis_terror_o,
    output logic [15:0]           error_count_o,
    output logic [TIdWidth-1:0]   first_err_tid_o,
    output logic [TDataWidth-1:0] first_err_data_o,
    output logic [NumStreams-1:0] stream_done_o,
    output logic                  all_done_o
);

    localparam int ActN = (CyclesActive < 1) ? 1 : CyclesActive;

    duty_state_e           state_r;
    duty_state_e           state_next_s;
    logic [15:0]           cnt_r;
    logic [15:0]           cnt_next_s;

    logic [TDataWidth-1:0] exp_data_s [NumStreams];
    logic [NumStreams-1:0] exp_last_s;
    logic [NumStreams-1:0] done_s;
    logic [NumStreams-1:0] hit_s;
    logic [31:0]           tid_ext_s;
    logic [31:0]           idx_s;
    logic                  in_range_s;
    logic [TDataWidth-1:0] sel_data_s;
    logic                  sel_last_s;
    logic                  sel_done_s;
    logic                  accept_s;
    logic                  xfer_err_s;

    logic                  terror_r;
    logic [15:0]           count_r;
    logic [TIdWidth-1:0]   first_tid_r;
    logic [TDataWidth-1:0] first_data_r;

    // Duty-cycle state register; counts clock cycles regardless of handshakes.
    always_ff @(posedge clk_s_axis_i) begin
        if (rst_s_axis_i) begin
            state_r <= DUTY_RESET;
            cnt_r   <= 16'd0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Duty-cycle next state: ACTIVE for ActN cycles, PAUSE for CyclesPause cycles.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            DUTY_RESET: begin
                state_next_s = DUTY_ACTIVE;
                cnt_next_s   = 16'd0;
            end
            DUTY_ACTIVE: begin
                if (CyclesPause == 0) begin
                    cnt_next_s = 16'd0;
                end else if (cnt_r == 16'(ActN - 1)) begin
                    state_next_s = DUTY_PAUSE;
                    cnt_next_s   = 16'd0;
                end else begin
                    cnt_next_s = cnt_r + 16'd1;
                end
            end
            DUTY_PAUSE: begin
                if (cnt_r == 16'(CyclesPause - 1)) begin
                    state_next_s = DUTY_ACTIVE;
                    cnt_next_s   = 16'd0;
                end else begin
                    cnt_next_s = cnt_r + 16'd1;
                end
            end
            default: begin
                state_next_s = DUTY_RESET;
                cnt_next_s   = 16'd0;
            end
        endcase
    end

    assign all_done_o      = (TargetMode == MODE_SINGLE) ? (&done_s) : 1'b0;
    assign stream_done_o   = done_s;
    assign s_axis_tready_o = (state_r == DUTY_ACTIVE) & ~all_done_o;
    assign accept_s        = s_axis_tvalid_i & s_axis_tready_o;

    // TID decode and one-hot select of the addressed stream's expectations.
    always_comb begin
        tid_ext_s  = 32'(s_axis_tid_i);
        idx_s      = tid_ext_s - 32'(TIdBase);
        in_range_s = (tid_ext_s >= 32'(TIdBase)) && (idx_s < 32'(NumStreams));
        sel_data_s = {TDataWidth{1'b0}};
        sel_last_s = 1'b0;
        sel_done_s = 1'b0;
        for (int k = 0; k < NumStreams; k++) begin
            hit_s[k]   = in_range_s && (idx_s == 32'(k));
            sel_data_s = sel_data_s | (exp_data_s[k] & {TDataWidth{hit_s[k]}});
            sel_last_s = sel_last_s | (exp_last_s[k] & hit_s[k]);
            sel_done_s = sel_done_s | (done_s[k] & hit_s[k]);
        end
    end

    assign xfer_err_s = accept_s & (~in_range_s
                                    | (s_axis_tdata_i != sel_data_s)
                                    | (s_axis_tdest_i != TDestWidth'(TDest))
                                    | (s_axis_tlast_i != sel_last_s)
                                    | sel_done_s);

    for (genvar k = 0; k < NumStreams; k++) begin : g_chan
        axi4_stream_target_type_2_chan #(
            .TDataWidth        (TDataWidth),
            .TargetMode        (TargetMode),
            .TlastTrigger      (TlastTrigger),
            .TransfersPerPacket(TransfersPerPacket),
            .PacketsPerFrame   (PacketsPerFrame),
            .FramesPerStream   (FramesPerStream),
            .TDataStart        (TDataInit + TDataWidth'(k)),
            .TDataIncr         (TDataIncr)
        ) u_chan (
            .clk     (clk_s_axis_i),
            .rst     (rst_s_axis_i),
            .accept  (accept_s & hit_s[k]),
            .exp_data(exp_data_s[k]),
            .exp_last(exp_last_s[k]),
            .done    (done_s[k])
        );
    end

    // Error aggregation: sticky flag, saturating count, first-error capture.
    always_ff @(posedge clk_s_axis_i) begin
        if (rst_s_axis_i) begin
            terror_r     <= 1'b0;
            count_r      <= 16'd0;
            first_tid_r  <= {TIdWidth{1'b0}};
            first_data_r <= {TDataWidth{1'b0}};
        end else if (xfer_err_s) begin
            terror_r <= 1'b1;
            if (count_r != 16'hFFFF) begin
                count_r <= count_r + 16'd1;
            end
            if (!terror_r) begin
                first_tid_r  <= s_axis_tid_i;
                first_data_r <= s_axis_tdata_i;
            end
        end
    end

    assign s_axis_terror_o  = terror_r;
    assign error_count_o    = count_r;
    assign first_err_tid_o  = first_tid_r;
    assign first_err_data_o = first_data_r;

endmodule

// File: tb/tb_axi4_stream_target_type_2.sv
// Directed bench for the multi-stream AXI4-Stream target. Three instances share
// the stimulus: a two-stream looping target, a two-stream single-pass target and a
// one-stream target with a 3-on/2-off tready duty cycle. Streams are 8 transfers
// long (4 per packet, 2 packets, 1 frame) so the hand-computed sequences stay short.
module tb_axi4_stream_target_type_2;
    import axi4_stream_traffic_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tvalid = 1'b0;
    logic [31:0] tdata = 32'h0;
    logic        tlast = 1'b0;
    logic [3:0]  tid = 4'h0;
    logic [3:0]  tdest = 4'h0;

    logic        loop_tready, loop_terror, loop_all;
    logic [15:0] loop_count;
    logic [3:0]  loop_ftid;
    logic [31:0] loop_fdata;
    logic [1:0]  loop_done;

    logic        sin_tready, sin_terror, sin_all;
    logic [15:0] sin_count;
    logic [3:0]  sin_ftid;
    logic [31:0] sin_fdata;
    logic [1:0]  sin_done;

    logic        dty_tready, dty_terror, dty_all;
    logic [15:0] dty_count;
    logic [3:0]  dty_ftid;
    logic [31:0] dty_fdata;
    logic [0:0]  dty_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi4_stream_target_type_2 #(.NumStreams(2), .FramesPerStream(1)) u_loop (
        .clk_s_axis_i(clk), .rst_s_axis_i(rst),
        .s_axis_tvalid_i(tvalid), .s_axis_tready_o(loop_tready),
        .s_axis_tdata_i(tdata), .s_axis_tlast_i(tlast),
        .s_axis_tid_i(tid), .s_axis_tdest_i(tdest),
        .s_axis_terror_o(loop_terror), .error_count_o(loop_count),
        .first_err_tid_o(loop_ftid), .first_err_data_o(loop_fdata),
        .stream_done_o(loop_done), .all_done_o(loop_all));

    axi4_stream_target_type_2 #(.NumStreams(2), .FramesPerStream(1),
                                .TargetMode(MODE_SINGLE)) u_single (
        .clk_s_axis_i(clk), .rst_s_axis_i(rst),
        .s_axis_tvalid_i(tvalid), .s_axis_tready_o(sin_tready),
        .s_axis_tdata_i(tdata), .s_axis_tlast_i(tlast),
        .s_axis_tid_i(tid), .s_axis_tdest_i(tdest),
        .s_axis_terror_o(sin_terror), .error_count_o(sin_count),
        .first_err_tid_o(sin_ftid), .first_err_data_o(sin_fdata),
        .stream_done_o(sin_done), .all_done_o(sin_all));

    axi4_stream_target_type_2 #(.NumStreams(1), .FramesPerStream(1),
                                .CyclesActive(3), .CyclesPause(2)) u_duty (
        .clk_s_axis_i(clk), .rst_s_axis_i(rst),
        .s_axis_tvalid_i(tvalid), .s_axis_tready_o(dty_tready),
        .s_axis_tdata_i(tdata), .s_axis_tlast_i(tlast),
        .s_axis_tid_i(tid), .s_axis_tdest_i(tdest),
        .s_axis_terror_o(dty_terror), .error_count_o(dty_count),
        .first_err_tid_o(dty_ftid), .first_err_data_o(dty_fdata),
        .stream_done_o(dty_done), .all_done_o(dty_all));

    function automatic logic rdy(input int which);
        case (which)
            0:       return loop_tready;
            1:       return sin_tready;
            default: return dty_tready;
        endcase
    endfunction

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic send(input int which, input logic [3:0] t, input logic [31:0] d,
                        input logic l, input logic [3:0] dst);
        int w;
        tvalid = 1'b1; tid = t; tdata = d; tlast = l; tdest = dst;
        w = 0;
        while (!rdy(which) && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (w >= 20) begin
            checks++; errors++;
            $display("FAIL send_timeout: instance %0d tready stayed 0, required 1", which);
        end
        @(negedge clk);
        tvalid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; tvalid = 1'b0; tlast = 1'b0; tdata = 32'h0; tid = 4'h0; tdest = 4'h0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; tvalid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (loop_tready !== 1'b0) begin errors++; $display("FAIL reset_tready: got %b, want 0", loop_tready); end
        checks++;
        if ({loop_terror, loop_count, loop_ftid, loop_fdata} !== 53'h0) begin
            errors++; $display("FAIL reset_errs: terror=%b count=%h tid=%h data=%h, want all 0",
                               loop_terror, loop_count, loop_ftid, loop_fdata);
        end
        checks++;
        if ({sin_done, sin_all, dty_tready} !== 4'b0000) begin
            errors++; $display("FAIL reset_done: done=%b all=%b dty_tready=%b, want 0", sin_done, sin_all, dty_tready);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (loop_tready !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b, want 1", loop_tready); end
    endtask

    task automatic test_loop_single_stream();
        do_reset();
        for (int i = 0; i < 8; i++) send(0, 4'd0, 32'hA0 + i, (i == 3) || (i == 7), 4'd0);
        checks++;
        if (loop_terror !== 1'b0 || loop_count !== 16'd0) begin
            errors++; $display("FAIL loop_seq: terror=%b count=%h, want 0/0000", loop_terror, loop_count);
        end
        send(0, 4'd0, 32'hA0, 1'b0, 4'd0);
        send(0, 4'd0, 32'hA1, 1'b0, 4'd0);
        checks++;
        if (loop_count !== 16'd0) begin errors++; $display("FAIL loop_wrap: count=%h, want 0000", loop_count); end
        checks++;
        if (loop_done !== 2'b00 || loop_all !== 1'b0) begin
            errors++; $display("FAIL loop_done: done=%b all=%b, want 00/0", loop_done, loop_all);
        end
    endtask

    task automatic test_interleave();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send(0, 4'd0, 32'hA0 + i, i == 3, 4'd0);
            send(0, 4'd1, 32'hA1 + i, i == 3, 4'd0);
        end
        checks++;
        if (loop_count !== 16'd0) begin errors++; $display("FAIL interleave_clean: count=%h, want 0000", loop_count); end
        do_reset();
        send(0, 4'd0, 32'hA0, 1'b0, 4'd0);
        send(0, 4'd1, 32'hA1, 1'b0, 4'd0);
        send(0, 4'd0, 32'hA1, 1'b0, 4'd0);
        send(0, 4'd1, 32'hFF, 1'b0, 4'd0);
        send(0, 4'd0, 32'hA2, 1'b0, 4'd0);
        send(0, 4'd1, 32'hA3, 1'b0, 4'd0);
        checks++;
        if (loop_count !== 16'd1 || loop_terror !== 1'b1) begin
            errors++; $display("FAIL corrupt_count: count=%h terror=%b, want 0001/1", loop_count, loop_terror);
        end
        checks++;
        if (loop_ftid !== 4'd1 || loop_fdata !== 32'hFF) begin
            errors++; $display("FAIL first_err: tid=%h data=%h, want 1/000000ff", loop_ftid, loop_fdata);
        end
        send(0, 4'd0, 32'h55, 1'b1, 4'd0);
        checks++;
        if (loop_count !== 16'd2 || loop_ftid !== 4'd1 || loop_fdata !== 32'hFF) begin
            errors++; $display("FAIL first_err_hold: count=%h tid=%h data=%h, want 0002/1/000000ff",
                               loop_count, loop_ftid, loop_fdata);
        end
    endtask

    task automatic test_single_mode();
        do_reset();
        for (int i = 0; i < 8; i++) send(1, 4'd0, 32'hA0 + i, (i == 3) || (i == 7), 4'd0);
        checks++;
        if (sin_done !== 2'b01 || sin_all !== 1'b0 || sin_tready !== 1'b1) begin
            errors++; $display("FAIL single_one_done: done=%b all=%b tready=%b, want 01/0/1", sin_done, sin_all, sin_tready);
        end
        send(1, 4'd0, 32'hA0, 1'b0, 4'd0);
        checks++;
        if (sin_count !== 16'd1) begin errors++; $display("FAIL single_after_done: count=%h, want 0001", sin_count); end
        do_reset();
        for (int i = 0; i < 8; i++) begin
            send(1, 4'd0, 32'hA0 + i, (i == 3) || (i == 7), 4'd0);
            if (i == 6) begin
                checks++;
                if (sin_done !== 2'b00) begin errors++; $display("FAIL single_early: done=%b, want 00", sin_done); end
            end
            send(1, 4'd1, 32'hA1 + i, (i == 3) || (i == 7), 4'd0);
        end
        checks++;
        if (sin_done !== 2'b11 || sin_all !== 1'b1 || sin_count !== 16'd0) begin
            errors++; $display("FAIL single_all_done: done=%b all=%b count=%h, want 11/1/0000", sin_done, sin_all, sin_count);
        end
        @(negedge clk);
        checks++;
        if (sin_tready !== 1'b0) begin errors++; $display("FAIL single_tready_off: got %b, want 0", sin_tready); end
    endtask

    task automatic test_duty_cycle();
        int  n;
        logic r;
        do_reset();
        n = 0;
        tvalid = 1'b1; tid = 4'd0; tdest = 4'd0; tdata = 32'hA0; tlast = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 15; i++) begin
            checks++;
            if (dty_tready !== ((i % 5) < 3)) begin
                errors++; $display("FAIL duty_tready[%0d]: got %b, want %b", i, dty_tready, (i % 5) < 3);
            end
            r = dty_tready;
            @(negedge clk);
            if (r) begin
                n++;
                tdata = 32'hA0 + (n % 8);
                tlast = (n % 4) == 3;
            end
        end
        tvalid = 1'b0;
        checks++;
        if (dty_count !== 16'd0 || dty_terror !== 1'b0) begin
            errors++; $display("FAIL duty_data: count=%h terror=%b, want 0000/0", dty_count, dty_terror);
        end
    endtask

    task automatic test_bad_tid_tdest();
        do_reset();
        send(0, 4'd5, 32'hA0, 1'b0, 4'd0);
        checks++;
        if (loop_count !== 16'd1) begin errors++; $display("FAIL bad_tid: count=%h, want 0001", loop_count); end
        send(0, 4'd0, 32'hA0, 1'b0, 4'd3);
        checks++;
        if (loop_count !== 16'd2) begin errors++; $display("FAIL bad_tdest: count=%h, want 0002", loop_count); end
        send(0, 4'd0, 32'hA1, 1'b0, 4'd0);
        checks++;
        if (loop_count !== 16'd2 || loop_ftid !== 4'd5 || loop_fdata !== 32'hA0) begin
            errors++; $display("FAIL tid5_no_state: count=%h tid=%h data=%h, want 0002/5/000000a0",
                               loop_count, loop_ftid, loop_fdata);
        end
        tvalid = 1'b1; tid = 4'd5; tdata = 32'h0; tlast = 1'b0; tdest = 4'd0;
        repeat (65532) @(negedge clk);
        checks++;
        if (loop_count !== 16'hFFFE) begin errors++; $display("FAIL sat_before: count=%h, want fffe", loop_count); end
        repeat (3) @(negedge clk);
        tvalid = 1'b0;
        checks++;
        if (loop_count !== 16'hFFFF) begin errors++; $display("FAIL saturate: count=%h, want ffff", loop_count); end
    endtask

    task automatic test_reset_mid_stream();
        do_reset();
        send(0, 4'd0, 32'hA0, 1'b0, 4'd0);
        send(0, 4'd0, 32'hA1, 1'b0, 4'd0);
        send(0, 4'd0, 32'h77, 1'b0, 4'd0);
        checks++;
        if (loop_count !== 16'd1) begin errors++; $display("FAIL pre_reset: count=%h, want 0001", loop_count); end
        tvalid = 1'b1; tid = 4'd0; tdata = 32'hA3; tlast = 1'b1; rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({loop_tready, loop_terror, loop_count, loop_ftid, loop_fdata} !== 54'h0) begin
            errors++; $display("FAIL mid_reset: tready=%b terror=%b count=%h tid=%h data=%h, want all 0",
                               loop_tready, loop_terror, loop_count, loop_ftid, loop_fdata);
        end
        rst = 1'b0; tvalid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) send(0, 4'd0, 32'hA0 + i, i == 3, 4'd0);
        checks++;
        if (loop_count !== 16'd0 || loop_terror !== 1'b0) begin
            errors++; $display("FAIL restart: count=%h terror=%b, want 0000/0", loop_count, loop_terror);
        end
    endtask

    initial begin
        test_reset();
        test_loop_single_stream();
        test_interleave();
        test_single_mode();
        test_duty_cycle();
        test_bad_tid_tdest();
        test_reset_mid_stream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
